// File: rtl/axi_if_pkg.sv
// axi_if_pkg: shared NIC crossbar constants and types.
//   NM / NS          : default master / real-slave counts
//   LGNM             : master index width
//   slv_arb_state_e  : per-slave write arbiter state
package axi_if_pkg;
  localparam int NM   = 4;
  localparam int NS   = 8;
  localparam int LGNM = $clog2(NM);

  typedef enum logic [1:0] {SA_IDLE, SA_OWNED, SA_DRAIN} slv_arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req       in  [N]          request vector
//   ptr       in  [$clog2(N)]  highest-priority index this cycle
//   valid     out              at least one request
//   grant_idx out  [$clog2(N)]  first requester at or after ptr (wrapping)
//   grant     out  [N]          one-hot of grant_idx, zero when !valid
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant
);
  logic [W-1:0] idx;

  // Scan from the far end toward ptr so the nearest requester is written last.
  always_comb begin
    valid     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        valid     = 1'b1;
        grant_idx = idx;
      end
    end
    if (valid) grant[grant_idx] = 1'b1;
  end
endmodule

// File: rtl/nic_slv_wr_arbiter.sv
// nic_slv_wr_arbiter: per-slave write-channel ownership for the NIC crossbar.
//   i_clk, i_reset        clock, synchronous active-high reset
//   wrequest_i    [NM][NS+1]  decoded write requests (bit NS = error slave, ignored)
//   mwgrant_i     [NM]        master holds a write grant
//   mwindex_i     [NM][LGS]   slave index of that grant
//   slv_wr_grant_o      [NM][NS]    slave j owned by someone other than m
//   wr_priority_bank_o  [NM][NS+1]  someone other than m has priority for j
//   write_qos_lockout_o [NM]        registered: master m must leave its channel
//   slv_busy_o [NS], slv_owner_o [NS][LGM]  per-slave ownership status
module nic_slv_wr_arbiter
  import axi_if_pkg::*;
#(
  parameter int NM       = axi_if_pkg::NM,
  parameter int NS       = axi_if_pkg::NS,
  parameter int HOLD_MAX = 16,
  localparam int NSF = NS + 1,
  localparam int LGS = $clog2(NSF),
  localparam int LGM = $clog2(NM)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NM-1:0][NSF-1:0]   wrequest_i,
  input  logic [NM-1:0]            mwgrant_i,
  input  logic [NM-1:0][LGS-1:0]   mwindex_i,
  output logic [NM-1:0][NS-1:0]    slv_wr_grant_o,
  output logic [NM-1:0][NSF-1:0]   wr_priority_bank_o,
  output logic [NM-1:0]            write_qos_lockout_o,
  output logic [NS-1:0]            slv_busy_o,
  output logic [NS-1:0][LGM-1:0]   slv_owner_o
);
  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  logic [NM-1:0][NS-1:0] lk_mj;   // [m][j]: slave j is draining master m
  logic [NM-1:0]         lk_any;
  logic [NM-1:0]         err_req_unused;

  for (genvar m = 0; m < NM; m++) begin : g_mst
    assign wr_priority_bank_o[m][NS] = 1'b0;
    assign err_req_unused[m]         = wrequest_i[m][NS];
    assign lk_any[m]                 = |lk_mj[m];
  end

  for (genvar j = 0; j < NS; j++) begin : g_slv
    logic [NM-1:0]  req_col, own_oh, pick_oh, gnt_col, pri_col;
    logic           pick_vld, rel, others, busy;
    logic [LGM-1:0] pick_idx, own_q, own_d, rr_q, rr_d;
    logic [HW-1:0]  hold_q, hold_d;
    slv_arb_state_e st_q, st_d;

    for (genvar m = 0; m < NM; m++) begin : g_col
      assign req_col[m]           = wrequest_i[m][j];
      assign slv_wr_grant_o[m][j] = gnt_col[m];
      assign wr_priority_bank_o[m][j] = pri_col[m];
      assign lk_mj[m][j]          = (st_q == SA_DRAIN) && own_oh[m];
    end

    rr_pick #(.N(NM)) u_pick (
      .req       (req_col),
      .ptr       (rr_q),
      .valid     (pick_vld),
      .grant_idx (pick_idx),
      .grant     (pick_oh)
    );

    assign own_oh = NM'(1) << own_q;
    assign others = |(req_col & ~own_oh);
    // The owner lets go by dropping its grant or retargeting it elsewhere.
    assign rel    = !mwgrant_i[own_q] || (mwindex_i[own_q] != LGS'(j));
    assign busy   = (st_q != SA_IDLE);

    // Combinational outputs are forced quiet while reset is held so a
    // request present during reset does not leak priority bits.
    assign gnt_col = (busy && !i_reset) ? ~own_oh : '0;
    assign pri_col = i_reset  ? '0      :
                     busy     ? ~own_oh :
                     pick_vld ? ~pick_oh : '0;

    assign slv_busy_o[j]  = busy;
    assign slv_owner_o[j] = own_q;

    always_comb begin
      st_d   = st_q;
      own_d  = own_q;
      rr_d   = rr_q;
      hold_d = hold_q;
      case (st_q)
        SA_IDLE: begin
          if (pick_vld) begin
            st_d   = SA_OWNED;
            own_d  = pick_idx;
            hold_d = '0;
          end
        end
        SA_OWNED, SA_DRAIN: begin
          // Release has priority over a simultaneous hold expiry.
          if (rel) begin
            st_d   = SA_IDLE;
            rr_d   = (own_q == LGM'(NM - 1)) ? '0 : own_q + 1'b1;
            hold_d = '0;
          end else if (st_q == SA_OWNED) begin
            if (HOLD_MAX != 0 && hold_q == HW'(HOLD_MAX))
              st_d = SA_DRAIN;
            else if (others && hold_q != HW'(HOLD_MAX))
              hold_d = hold_q + 1'b1;
          end
        end
        default: st_d = SA_IDLE;
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        st_q   <= SA_IDLE;
        own_q  <= '0;
        rr_q   <= '0;
        hold_q <= '0;
      end else begin
        st_q   <= st_d;
        own_q  <= own_d;
        rr_q   <= rr_d;
        hold_q <= hold_d;
      end
    end
  end

  // Lockout follows DRAIN by one cycle on both entry and exit.
  always_ff @(posedge i_clk) begin
    if (i_reset) write_qos_lockout_o <= '0;
    else         write_qos_lockout_o <= lk_any;
  end
endmodule

// File: tb/tb_nic_slv_wr_arbiter.sv
// tb_nic_slv_wr_arbiter: scenario-task bench with an expected-owner scoreboard.
module tb_nic_slv_wr_arbiter;
  localparam int NM = 4, NS = 8, NSF = NS + 1, LGS = 4, LGM = 2, HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NM-1:0][NSF-1:0] wreq;
  logic [NM-1:0]          mwg;
  logic [NM-1:0][LGS-1:0] mwi;
  logic [NM-1:0][NS-1:0]  gnt;
  logic [NM-1:0][NSF-1:0] pri;
  logic [NM-1:0]          lock;
  logic [NS-1:0]          busy;
  logic [NS-1:0][LGM-1:0] owner;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  nic_slv_wr_arbiter #(.NM(NM), .NS(NS), .HOLD_MAX(HOLD)) dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .wrequest_i          (wreq),
    .mwgrant_i           (mwg),
    .mwindex_i           (mwi),
    .slv_wr_grant_o      (gnt),
    .wr_priority_bank_o  (pri),
    .write_qos_lockout_o (lock),
    .slv_busy_o          (busy),
    .slv_owner_o         (owner)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] m, input logic [3:0] s);
    wreq[m]    = '0;
    wreq[m][s] = 1'b1;
    mwg[m]     = 1'b1;
    mwi[m]     = s;
  endtask

  task automatic drop(input logic [1:0] m);
    wreq[m] = '0;
    mwg[m]  = 1'b0;
    mwi[m]  = '0;
  endtask

  task automatic clear_in();
    wreq = '0;
    mwg  = '0;
    mwi  = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    clear_in();
    rst = 1'b1;
    req(2'd1, 4'd2);
    step(2);
    n_chk++; if (gnt !== '0)  $display("FAIL reset_gnt: got %h want 0", gnt);   else n_pass++;
    n_chk++; if (pri !== '0)  $display("FAIL reset_pri: got %h want 0", pri);   else n_pass++;
    n_chk++; if (lock !== '0) $display("FAIL reset_lock: got %b want 0", lock); else n_pass++;
    n_chk++; if (busy !== '0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (owner !== '0) $display("FAIL reset_owner: got %h want 0", owner); else n_pass++;
    exp_q.push_back(1);
    rst = 1'b0;
    step();
    e = exp_q.pop_front();
    n_chk++; if (busy[2] !== 1'b1) $display("FAIL rst_rel_busy: got %b want 1", busy[2]); else n_pass++;
    n_chk++; if (owner[2] !== LGM'(e)) $display("FAIL rst_rel_owner: got %0d want %0d", owner[2], e); else n_pass++;
    n_chk++; if (gnt[0][2] !== 1'b1) $display("FAIL rst_rel_gnt0: got %b want 1", gnt[0][2]); else n_pass++;
    n_chk++; if (gnt[1][2] !== 1'b0) $display("FAIL rst_rel_gnt1: got %b want 0", gnt[1][2]); else n_pass++;
    drop(2'd1);
    step(2);
    n_chk++; if (busy !== '0) $display("FAIL rst_drop_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    req(2'd0, 4'd3);
    req(2'd2, 4'd3);
    #1;
    n_chk++; if (pri[1][3] !== 1'b1 || pri[0][3] !== 1'b0 || pri[2][3] !== 1'b1)
      $display("FAIL rr_pick0_pri: got %b%b%b want 101", pri[2][3], pri[1][3], pri[0][3]); else n_pass++;
    exp_q.push_back(0);
    step();
    e = exp_q.pop_front();
    n_chk++; if (busy[3] !== 1'b1 || owner[3] !== LGM'(e))
      $display("FAIL rr_owner0: busy %b owner %0d want 1/%0d", busy[3], owner[3], e); else n_pass++;
    n_chk++; if (gnt[2][3] !== 1'b1 || gnt[0][3] !== 1'b0)
      $display("FAIL rr_gnt0: got %b%b want 10", gnt[2][3], gnt[0][3]); else n_pass++;
    drop(2'd0);
    exp_q.push_back(2);
    step();
    n_chk++; if (busy[3] !== 1'b0) $display("FAIL rr_bubble: busy got %b want 0", busy[3]); else n_pass++;
    n_chk++; if (pri[2][3] !== 1'b0 || pri[0][3] !== 1'b1)
      $display("FAIL rr_bubble_pri: got %b%b want 01", pri[2][3], pri[0][3]); else n_pass++;
    step();
    e = exp_q.pop_front();
    n_chk++; if (busy[3] !== 1'b1 || owner[3] !== LGM'(e))
      $display("FAIL rr_owner2: busy %b owner %0d want 1/%0d", busy[3], owner[3], e); else n_pass++;
    // After master 2 releases the pointer sits at 3, so 3 beats 0.
    drop(2'd2);
    step();
    req(2'd0, 4'd3);
    req(2'd3, 4'd3);
    exp_q.push_back(3);
    step();
    e = exp_q.pop_front();
    n_chk++; if (owner[3] !== LGM'(e)) $display("FAIL rr_wrap_owner: got %0d want %0d", owner[3], e); else n_pass++;
  endtask

  task automatic test_preempt();
    int e;
    do_reset();
    req(2'd1, 4'd0);
    req(2'd3, 4'd0);
    exp_q.push_back(1);
    step();
    e = exp_q.pop_front();
    n_chk++; if (owner[0] !== LGM'(e) || busy[0] !== 1'b1)
      $display("FAIL pre_owner1: owner %0d busy %b want %0d/1", owner[0], busy[0], e); else n_pass++;
    step(4);
    n_chk++; if (lock !== '0) $display("FAIL pre_early_lock: got %b want 0", lock); else n_pass++;
    step();
    n_chk++; if (lock !== '0) $display("FAIL pre_drain_lock: got %b want 0", lock); else n_pass++;
    step();
    n_chk++; if (lock !== 4'b0010) $display("FAIL pre_lock_rise: got %b want 0010", lock); else n_pass++;
    n_chk++; if (gnt[3][0] !== 1'b1) $display("FAIL pre_drain_gnt: got %b want 1", gnt[3][0]); else n_pass++;
    drop(2'd1);
    exp_q.push_back(3);
    step();
    n_chk++; if (busy[0] !== 1'b0 || lock !== 4'b0010)
      $display("FAIL pre_release: busy %b lock %b want 0/0010", busy[0], lock); else n_pass++;
    step();
    e = exp_q.pop_front();
    n_chk++; if (lock !== '0) $display("FAIL pre_lock_fall: got %b want 0", lock); else n_pass++;
    n_chk++; if (busy[0] !== 1'b1 || owner[0] !== LGM'(e))
      $display("FAIL pre_owner3: busy %b owner %0d want 1/%0d", busy[0], owner[0], e); else n_pass++;
  endtask

  task automatic test_expiry_release();
    int e;
    do_reset();
    req(2'd1, 4'd0);
    req(2'd3, 4'd0);
    exp_q.push_back(1);
    step();
    e = exp_q.pop_front();
    n_chk++; if (owner[0] !== LGM'(e)) $display("FAIL exp_owner1: got %0d want %0d", owner[0], e); else n_pass++;
    step(4);
    drop(2'd1);
    exp_q.push_back(3);
    step();
    n_chk++; if (busy[0] !== 1'b0 || lock !== '0)
      $display("FAIL exp_to_idle: busy %b lock %b want 0/0", busy[0], lock); else n_pass++;
    step();
    e = exp_q.pop_front();
    n_chk++; if (lock !== '0) $display("FAIL exp_no_lock: got %b want 0", lock); else n_pass++;
    n_chk++; if (owner[0] !== LGM'(e) || busy[0] !== 1'b1)
      $display("FAIL exp_owner3: owner %0d busy %b want %0d/1", owner[0], busy[0], e); else n_pass++;
    step(3);
    n_chk++; if (lock !== '0) $display("FAIL exp_lock_late: got %b want 0", lock); else n_pass++;
  endtask

  task automatic test_independent();
    int e;
    do_reset();
    for (int i = 0; i < NM; i++) begin
      req(2'(i), 4'(i));
      exp_q.push_back(i);
    end
    #1;
    for (int i = 0; i < NM; i++) begin
      logic [1:0] m, o;
      m = 2'(i);
      o = m + 2'd1;
      n_chk++; if (pri[m][m] !== 1'b0 || pri[o][m] !== 1'b1)
        $display("FAIL ind_idle_pri%0d: self %b other %b want 0/1", i, pri[m][m], pri[o][m]); else n_pass++;
    end
    step();
    for (int i = 0; i < NM; i++) begin
      logic [1:0] m;
      m = 2'(i);
      e = exp_q.pop_front();
      n_chk++; if (busy[m] !== 1'b1 || owner[m] !== LGM'(e) || pri[m][m] !== 1'b0)
        $display("FAIL ind_owned%0d: busy %b owner %0d pri %b want 1/%0d/0", i, busy[m], owner[m], pri[m][m], e);
      else n_pass++;
    end
  endtask

  task automatic test_error_slave();
    do_reset();
    wreq[2][8] = 1'b1;
    #1;
    for (int i = 0; i < NM; i++) begin
      logic [1:0] m;
      m = 2'(i);
      n_chk++; if (pri[m][8] !== 1'b0) $display("FAIL err_pri%0d: got %b want 0", i, pri[m][8]); else n_pass++;
    end
    step(2);
    n_chk++; if (busy !== '0 || gnt !== '0 || pri !== '0)
      $display("FAIL err_state: busy %b gnt %h pri %h want 0", busy, gnt, pri); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_preempt();
    test_expiry_release();
    test_independent();
    test_error_slave();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
